reg_file_2w2r: RTL
==================

// Module: reg_file_2w2r
// PURPOSE
//  Parametrised register file: 2 write ports, 2 registered read ports.
//  Adds write-to-read bypass, write-port priority and a sequenced bulk-clear engine.
//  Next-generation datapath storage for the digital-design cores.
//  Replaces fixed 8-bit x 16-entry, 1-write-port files.
// PARAMETERS
//  DATA_W    8  data width in bits
//  ADDR_W    4  address width; DEPTH = 2**ADDR_W entries (no out-of-range addresses)
//  BYPASS    1  1: read sees same-edge write data; 0: read sees pre-write contents
//  ZERO_REG  0  1: entry 0 always reads 0; writes to entry 0 are discarded
// PORTS
//  clk    in   1       single clock; all state updates on its rising edge
//  reset  in   1       synchronous reset, active-low (sampled at posedge clk)
//  we0    in   1       write enable, port 0
//  wa0    in   ADDR_W  write address, port 0
//  wd0    in   DATA_W  write data, port 0
//  we1    in   1       write enable, port 1 (higher priority)
//  wa1    in   ADDR_W  write address, port 1
//  wd1    in   DATA_W  write data, port 1
//  ra1    in   ADDR_W  read address, port 1
//  ra2    in   ADDR_W  read address, port 2
//  rd1    out  DATA_W  read data, port 1 (registered)
//  rd2    out  DATA_W  read data, port 2 (registered)
//  clr    in   1       bulk-clear request (single-cycle pulse or level)
//  busy   out  1       high while the clear sequence runs
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//  - all entries = 0; rd1 = rd2 = 0; busy = 0; FSM = IDLE; clear counter = 0
//  - overrides every other input in that cycle
//  Writes:
//  - if weN==1 at posedge, entry waN <= wdN
//  - we0 & we1 to the same address: port 1 wins
//  - writes to different addresses: both take effect
//  Reads:
//  - 1-cycle latency: rdN at edge t+1 holds entry raN as sampled at edge t
//  - rdN holds its value between edges; ra1 == ra2 is legal
//  - BYPASS=1 and a write to raN at edge t: rdN = the winning write data
//  - BYPASS=0: rdN = the contents before that write
//  - ZERO_REG=1: a read of address 0 returns 0 regardless of writes
//  Clear FSM:
//  - states IDLE, CLEAR; counter cnt is ADDR_W bits wide
//  - IDLE: clr==1 at edge -> CLEAR, cnt <= 0, busy <= 1
//  - CLEAR: each edge, entry cnt <= 0 and cnt <= cnt+1
//  - CLEAR: at cnt == DEPTH-1, clear that entry, -> IDLE, busy <= 0
//  - busy is high for exactly DEPTH cycles
//  - in CLEAR, we0/we1 are ignored (writes dropped, no error flag)
//  - in CLEAR, clr is ignored; a new request is accepted only from IDLE
//  - reads stay live during CLEAR; the clear write to entry cnt is a write of 0 for bypass
//  - reset during CLEAR: immediate full reset, FSM -> IDLE, busy = 0
// TESTING
//  1. Reset: hold reset=0 for 2 cycles -> rd1=rd2=0, busy=0; read all 16 addresses -> 0.
//  2. Write/read: we0 @ addr 10 with 0x03; then ra1=10 -> rd1=0x03 one cycle later; rd2 @ addr 1 = 0x00.
//  3. Collision and bypass (BYPASS=1):
//     - same edge: we0 @5=0x24, we1 @5=0xF1, ra1=5 -> rd1=0xF1 next cycle, entry 5 = 0xF1
//     - repeat with BYPASS=0 -> rd1 = old value (0x00)
//  4. Bulk clear:
//     - fill all 16 entries with 0xAA, pulse clr -> busy high exactly 16 cycles
//     - we0 @3=0x55 mid-clear is dropped; all entries 0x00 afterwards
//     - clr asserted while busy does not restart the count
//  5. Reset mid-clear: assert reset=0 at cycle 7 of CLEAR -> busy=0 next edge, all entries 0, FSM IDLE.
//  6. ZERO_REG=1: we1 @0=0xFF -> rd of addr 0 = 0x00; we1 @1=0xFF -> rd of addr 1 = 0xFF.

Source files
------------

// File: rtl/reg_file_2w2r.sv
// reg_file_2w2r: 2-write / 2-read register file with registered reads, same-edge bypass,
// optional hard-wired zero entry and a sequenced bulk-clear engine.  Rev 1.0
`default_nettype none

module reg_file_2w2r #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              clr,
  output logic              busy
);

  localparam int                c_DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST   = ADDR_W'(c_DEPTH - 1);
  localparam bit                c_BYPASS = (BYPASS != 0);
  localparam bit                c_ZERO   = (ZERO_REG != 0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_busy;
  logic [DATA_W-1:0]   r_mem [c_DEPTH];
  logic [DATA_W-1:0]   r_rd1;
  logic [DATA_W-1:0]   r_rd2;

  logic                w_in_clear;
  logic                w_wr0;
  logic                w_wr1;
  logic [ADDR_W-1:0]   w_ra   [2];
  logic [DATA_W-1:0]   w_rd_nx[2];

  assign w_in_clear = (r_state == ST_CLEAR);

  // User writes are dropped while clearing; entry 0 is never written when hard-wired to zero.
  assign w_wr0 = we0 && !w_in_clear && !(c_ZERO && (wa0 == '0));
  assign w_wr1 = we1 && !w_in_clear && !(c_ZERO && (wa1 == '0));

  assign w_ra[0] = ra1;
  assign w_ra[1] = ra2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd_nx[p] = r_mem[w_ra[p]];
      if (c_BYPASS) begin
        if (w_in_clear) begin
          if (w_ra[p] == r_cnt) begin
            w_rd_nx[p] = '0;
          end
        end else if (w_wr1 && (wa1 == w_ra[p])) begin
          w_rd_nx[p] = wd1;
        end else if (w_wr0 && (wa0 == w_ra[p])) begin
          w_rd_nx[p] = wd0;
        end
      end
      if (c_ZERO && (w_ra[p] == '0)) begin
        w_rd_nx[p] = '0;
      end
    end
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem <= '{default: '0};
    end else if (w_in_clear) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_wr0) begin
        r_mem[wa0] <= wd0;
      end
      if (w_wr1) begin
        r_mem[wa1] <= wd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
    end else begin
      r_rd1 <= w_rd_nx[0];
      r_rd2 <= w_rd_nx[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd1  = r_rd1;
  assign rd2  = r_rd2;
  assign busy = r_busy;

endmodule

`default_nettype wire
